imm_pack_loader: RTL and testbench

//  Inverse of the immediate generator: takes a 32-bit immediate value plus an instruction template,

---
 rtl/imm_pack_loader.sv | 191 +++++++++++++++++++
 tb/tb_imm_pack_loader.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_pack_loader.sv
//==============================================================================
// Module      : imm_pack_loader
// Description : Range-checks an immediate for the selected format, scatters it
//               into an instruction template, and writes words sequentially.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module imm_pack_loader #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_imm_sel,
    input  logic [31:0]       in_value,
    input  logic [31:0]       in_template,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  err_count
);

    localparam logic [2:0] c_SEL_I  = 3'b000;
    localparam logic [2:0] c_SEL_SH = 3'b001;
    localparam logic [2:0] c_SEL_S  = 3'b010;
    localparam logic [2:0] c_SEL_B  = 3'b011;
    localparam logic [2:0] c_SEL_U  = 3'b100;
    localparam logic [2:0] c_SEL_J  = 3'b101;

    localparam logic [ADDR_W-1:0] c_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        c_IDLE = 2'd0,
        c_RUN  = 2'd1,
        c_FIN  = 2'd2
    } state_t;

    state_t            r_state_q,   w_state_d;
    logic [CNT_W-1:0]  r_rem_q,     w_rem_d;
    logic [ADDR_W-1:0] r_addr_q,    w_addr_d;
    logic              r_we_q,      w_we_d;
    logic [ADDR_W-1:0] r_waddr_q,   w_waddr_d;
    logic [31:0]       r_wdata_q,   w_wdata_d;
    logic              r_done_q,    w_done_d;
    logic              r_err_q,     w_err_d;
    logic [CNT_W-1:0]  r_err_cnt_q, w_err_cnt_d;

    logic [31:0] w_enc_word;
    logic        w_enc_legal;
    logic        w_handshake;

    // Illegal requests pass the template through untouched.
    always_comb begin
        w_enc_word  = in_template;
        w_enc_legal = 1'b0;
        case (in_imm_sel)
            c_SEL_I: begin
                w_enc_word[31:20] = in_value[11:0];
                w_enc_legal       = (&in_value[31:11]) | ~(|in_value[31:11]);
            end
            c_SEL_SH: begin
                w_enc_word[24:20] = in_value[4:0];
                w_enc_legal       = ~(|in_value[31:5]);
            end
            c_SEL_S: begin
                w_enc_word[31:25] = in_value[11:5];
                w_enc_word[11:7]  = in_value[4:0];
                w_enc_legal       = ~(|in_value[31:12]);
            end
            c_SEL_B: begin
                w_enc_word[31]    = in_value[12];
                w_enc_word[7]     = in_value[11];
                w_enc_word[30:25] = in_value[10:5];
                w_enc_word[11:8]  = in_value[4:1];
                w_enc_legal       = ~in_value[0] &
                                    ((&in_value[31:12]) | ~(|in_value[31:12]));
            end
            c_SEL_U: begin
                w_enc_word[31:12] = in_value[19:0];
                w_enc_legal       = (&in_value[31:19]) | ~(|in_value[31:19]);
            end
            c_SEL_J: begin
                w_enc_word[31]    = in_value[20];
                w_enc_word[19:12] = in_value[19:12];
                w_enc_word[20]    = in_value[11];
                w_enc_word[30:21] = in_value[10:1];
                w_enc_legal       = ~in_value[0] &
                                    ((&in_value[31:20]) | ~(|in_value[31:20]));
            end
            default: w_enc_legal = 1'b0;
        endcase
        if (!w_enc_legal) begin
            w_enc_word = in_template;
        end
    end

    assign in_ready    = (r_state_q == c_RUN) && (r_rem_q != '0);
    assign w_handshake = in_valid & in_ready;

    always_comb begin
        w_state_d   = r_state_q;
        w_rem_d     = r_rem_q;
        w_addr_d    = r_addr_q;
        w_we_d      = 1'b0;
        w_waddr_d   = r_waddr_q;
        w_wdata_d   = r_wdata_q;
        w_done_d    = 1'b0;
        w_err_d     = r_err_q;
        w_err_cnt_d = r_err_cnt_q;
        case (r_state_q)
            c_IDLE: begin
                if (start) begin
                    w_addr_d    = base_addr;
                    w_rem_d     = word_count;
                    w_err_d     = 1'b0;
                    w_err_cnt_d = '0;
                    w_state_d   = (word_count == '0) ? c_FIN : c_RUN;
                end
            end
            c_RUN: begin
                if (w_handshake) begin
                    w_we_d    = 1'b1;
                    w_waddr_d = r_addr_q;
                    w_wdata_d = w_enc_word;
                    w_addr_d  = r_addr_q + c_ADDR_ONE;
                    w_rem_d   = r_rem_q - c_CNT_ONE;
                    if (!w_enc_legal) begin
                        w_err_d = 1'b1;
                        if (!(&r_err_cnt_q)) begin
                            w_err_cnt_d = r_err_cnt_q + c_CNT_ONE;
                        end
                    end
                    if (r_rem_q == c_CNT_ONE) begin
                        w_state_d = c_FIN;
                    end
                end
            end
            // done is registered so it lands the cycle after the final write.
            c_FIN: begin
                w_done_d  = 1'b1;
                w_state_d = c_IDLE;
            end
            default: w_state_d = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= c_IDLE;
            r_rem_q     <= '0;
            r_addr_q    <= '0;
            r_we_q      <= 1'b0;
            r_waddr_q   <= '0;
            r_wdata_q   <= '0;
            r_done_q    <= 1'b0;
            r_err_q     <= 1'b0;
            r_err_cnt_q <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_rem_q     <= w_rem_d;
            r_addr_q    <= w_addr_d;
            r_we_q      <= w_we_d;
            r_waddr_q   <= w_waddr_d;
            r_wdata_q   <= w_wdata_d;
            r_done_q    <= w_done_d;
            r_err_q     <= w_err_d;
            r_err_cnt_q <= w_err_cnt_d;
        end
    end

    assign imem_we    = r_we_q;
    assign imem_addr  = r_waddr_q;
    assign imem_wdata = r_wdata_q;
    assign busy       = (r_state_q == c_RUN);
    assign done       = r_done_q;
    assign err        = r_err_q;
    assign err_count  = r_err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_imm_pack_loader.sv
//==============================================================================
// Module      : tb_imm_pack_loader
// Description : Self-checking bench for imm_pack_loader (vector table + random).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_imm_pack_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  base_addr;
    logic [7:0]  word_count;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_imm_sel;
    logic [31:0] in_value;
    logic [31:0] in_template;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  err_count;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  exp_addr;
    int          exp_errs;

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] value;
        logic [31:0] templ;
        logic [31:0] exp_data;
        bit          legal;
    } vec_t;

    vec_t vecs[15];

    imm_pack_loader #(.ADDR_W(8), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_imm_sel (in_imm_sel),
        .in_value   (in_value),
        .in_template(in_template),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Which value bit lands on instruction bit ib (-1: template bit kept).
    function automatic int src_bit(input logic [2:0] sel, input int ib);
        case (sel)
            3'd0: return (ib >= 20) ? ib - 20 : -1;
            3'd1: return (ib >= 20 && ib <= 24) ? ib - 20 : -1;
            3'd2: begin
                if (ib >= 25) return ib - 20;
                if (ib >= 7 && ib <= 11) return ib - 7;
                return -1;
            end
            3'd3: begin
                if (ib == 31) return 12;
                if (ib == 7) return 11;
                if (ib >= 25) return ib - 20;
                if (ib >= 8 && ib <= 11) return ib - 7;
                return -1;
            end
            3'd4: return (ib >= 12) ? ib - 12 : -1;
            3'd5: begin
                if (ib == 31) return 20;
                if (ib >= 12 && ib <= 19) return ib;
                if (ib == 20) return 11;
                if (ib >= 21) return ib - 20;
                return -1;
            end
            default: return -1;
        endcase
    endfunction

    function automatic void ref_model(input logic [2:0] sel, input logic [31:0] v,
                                      input logic [31:0] t, output logic [31:0] d,
                                      output bit legal);
        longint s;
        int     k;
        bit     even;
        s    = longint'($signed(v));
        even = (v % 2) == 0;
        case (sel)
            3'd0:    legal = (s >= -2048) && (s <= 2047);
            3'd1:    legal = v < 32;
            3'd2:    legal = v < 4096;
            3'd3:    legal = even && (s >= -4096) && (s <= 4095);
            3'd4:    legal = (s >= -524288) && (s <= 524287);
            3'd5:    legal = even && (s >= -1048576) && (s <= 1048575);
            default: legal = 1'b0;
        endcase
        d = t;
        if (legal) begin
            for (int ib = 0; ib < 32; ib++) begin
                k = src_bit(sel, ib);
                if (k >= 0) d[ib] = v[k];
            end
        end
    endfunction

    task automatic do_start(input logic [7:0] b, input logic [7:0] c);
        @(negedge clk);
        base_addr  = b;
        word_count = c;
        start      = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        exp_addr = b;
        exp_errs = 0;
        @(negedge clk);
        chk("busy_after_start", 32'(busy), 32'(c != 8'd0));
        chk("err_cleared", 32'(err), 32'd0);
        chk("err_count_cleared", 32'(err_count), 32'd0);
    endtask

    task automatic send(input logic [2:0] sel, input logic [31:0] v, input logic [31:0] t,
                        input logic [31:0] ed, input bit el, input bit last);
        int n;
        in_imm_sel  = sel;
        in_value    = v;
        in_template = t;
        in_valid    = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        if (!el && exp_errs < 255) exp_errs++;
        @(negedge clk);
        chk("imem_we", 32'(imem_we), 32'd1);
        chk("imem_addr", 32'(imem_addr), 32'(exp_addr));
        chk("imem_wdata", imem_wdata, ed);
        chk("err", 32'(err), 32'(exp_errs != 0));
        chk("err_count", 32'(err_count), 32'(exp_errs));
        exp_addr = exp_addr + 8'd1;
        if (last) begin
            chk("ready_after_last", 32'(in_ready), 32'd0);
            @(negedge clk);
            chk("done_pulse", 32'(done), 32'd1);
            chk("we_after_last", 32'(imem_we), 32'd0);
            @(negedge clk);
            chk("done_single", 32'(done), 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ed, v, r, t;
        bit          el;
        logic [2:0]  sel;
        int          k;

        vecs[0]  = '{3'd0, 32'hFFFFFFFF, 32'h00000013, 32'hFFF00013, 1'b1};
        vecs[1]  = '{3'd3, 32'hFFFFFFFE, 32'h00000063, 32'hFE000FE3, 1'b1};
        vecs[2]  = '{3'd4, 32'h00012345, 32'h00000037, 32'h12345037, 1'b1};
        vecs[3]  = '{3'd0, 32'h00000800, 32'h00000013, 32'h00000013, 1'b0};
        vecs[4]  = '{3'd5, 32'h00000003, 32'h0000006F, 32'h0000006F, 1'b0};
        vecs[5]  = '{3'd1, 32'h00000020, 32'h00001013, 32'h00001013, 1'b0};
        vecs[6]  = '{3'd6, 32'h00000005, 32'h00000013, 32'h00000013, 1'b0};
        vecs[7]  = '{3'd1, 32'h0000001F, 32'h40005013, 32'h41F05013, 1'b1};
        vecs[8]  = '{3'd2, 32'h00000FFF, 32'h00002023, 32'hFE002FA3, 1'b1};
        vecs[9]  = '{3'd2, 32'h00001000, 32'h00002023, 32'h00002023, 1'b0};
        vecs[10] = '{3'd5, 32'h000FFFFE, 32'h0000006F, 32'h7FFFF06F, 1'b1};
        vecs[11] = '{3'd4, 32'h00080000, 32'h00000037, 32'h00000037, 1'b0};
        vecs[12] = '{3'd3, 32'hFFFFF000, 32'h00000063, 32'h80000063, 1'b1};
        vecs[13] = '{3'd0, 32'hFFFFF800, 32'h00000013, 32'h80000013, 1'b1};
        vecs[14] = '{3'd7, 32'h00000000, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};

        rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
        in_valid = 1'b0; in_imm_sel = '0; in_value = '0; in_template = '0;
        exp_addr = '0; exp_errs = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_imem_we", 32'(imem_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);
        chk("rst_imem_wdata", imem_wdata, 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        rst = 1'b0;

        // Single I-type word.
        do_start(8'h10, 8'd1);
        send(3'd0, 32'hFFFFFFFF, 32'h00000013, 32'hFFF00013, 1'b1, 1'b1);

        // Out-of-range I value, then the next start must clear the error state.
        do_start(8'h20, 8'd1);
        send(3'd0, 32'h00000800, 32'h00000013, 32'h00000013, 1'b0, 1'b1);
        chk("err_held_after_burst", 32'(err), 32'd1);
        do_start(8'h30, 8'd3);
        send(3'd5, 32'h00000003, 32'h0000006F, 32'h0000006F, 1'b0, 1'b0);
        send(3'd1, 32'h00000020, 32'h00001013, 32'h00001013, 1'b0, 1'b0);
        send(3'd6, 32'h00000005, 32'h00000013, 32'h00000013, 1'b0, 1'b1);
        chk("err_count_three", 32'(err_count), 32'd3);

        do_start(8'h40, 8'd2);
        send(3'd3, 32'hFFFFFFFE, 32'h00000063, 32'hFE000FE3, 1'b1, 1'b0);
        send(3'd4, 32'h00012345, 32'h00000037, 32'h12345037, 1'b1, 1'b1);

        // Address wrap with gapped valid and a start pulse that must be ignored.
        do_start(8'hFE, 8'd3);
        send(3'd0, 32'h00000005, 32'h00000013, 32'h00500013, 1'b1, 1'b0);
        repeat (2) begin
            @(negedge clk);
            chk("gap_no_we", 32'(imem_we), 32'd0);
        end
        base_addr = 8'h55; word_count = 8'd9; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        send(3'd4, 32'h00000001, 32'h00000037, 32'h00001037, 1'b1, 1'b0);
        @(negedge clk);
        chk("gap_no_we2", 32'(imem_we), 32'd0);
        send(3'd2, 32'h00000021, 32'h00002023, 32'h00002023 | 32'h00000080 | 32'h02000000, 1'b1, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("no_extra_done", 32'(done), 32'd0);
            chk("idle_not_busy", 32'(busy), 32'd0);
        end

        // Vector table as one burst.
        do_start(8'h80, 8'd15);
        for (int i = 0; i < 15; i++) begin
            send(vecs[i].sel, vecs[i].value, vecs[i].templ, vecs[i].exp_data,
                 vecs[i].legal, i == 14);
        end

        // Randomized burst against the reference model.
        do_start(8'($urandom), 8'd40);
        for (int i = 0; i < 40; i++) begin
            sel = 3'($urandom_range(0, 7));
            r   = $urandom;
            k   = $urandom_range(2, 24);
            v   = 32'($signed(r) >>> (32 - k));
            if ($urandom_range(0, 1) == 1) v[0] = 1'b0;
            if ($urandom_range(0, 7) == 0) v = $urandom;
            t = $urandom;
            ref_model(sel, v, t, ed, el);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(sel, v, t, ed, el, i == 39);
        end

        // Reset in the middle of a burst, then an empty burst.
        do_start(8'h60, 8'd4);
        send(3'd0, 32'h00000001, 32'h00000013, 32'h00100013, 1'b1, 1'b0);
        in_imm_sel = 3'd0; in_value = 32'h2; in_template = 32'h13; in_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_imem_we", 32'(imem_we), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_imem_addr", 32'(imem_addr), 32'd0);
        chk("mid_rst_imem_wdata", imem_wdata, 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("mid_rst_no_we", 32'(imem_we), 32'd0);
            chk("mid_rst_no_done", 32'(done), 32'd0);
        end
        in_valid = 1'b0;
        do_start(8'h70, 8'd0);
        chk("empty_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("empty_done", 32'(done), 32'd1);
        chk("empty_no_we", 32'(imem_we), 32'd0);
        @(negedge clk);
        chk("empty_done_single", 32'(done), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
